// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and FSM state encoding for the register-file dump reader.
// Optional build macro used by the top: REGDUMP_SKIP_ZERO_EN (suppress zero-valued entries).
package regfile_dump_reader_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/regdump_idx_ctr.sv
// Register index counter for the dump walk: clear-to-zero, increment, and last-index flag.
module regdump_idx_ctr
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              zero,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic              last_c
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;

  // Next index: zero wins over increment; saturates at the last register.
  always_comb begin
    idx_d = idx_q;
    if (zero) begin
      idx_d = '0;
    end else if (inc && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx    = idx_q;
  assign last_c = (idx_q == LAST_IDX);

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks registers 0..NUM_REGS-1 through a registered read port and streams (index, value)
// over valid/ready. Build macro REGDUMP_SKIP_ZERO_EN drops zero-valued entries from the stream.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [ADDR_W-1:0] idx;
  logic              idx_last_c;
  logic              idx_zero_c;
  logic              idx_inc_c;

  regdump_idx_ctr #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_idx_ctr (
    .clk    (clk),
    .clr    (clr),
    .zero   (idx_zero_c),
    .inc    (idx_inc_c),
    .idx    (idx),
    .last_c (idx_last_c)
  );

  // Next-state and next-output logic; flag outputs decode the next state so they stay registered.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    idx_zero_c  = 1'b0;
    idx_inc_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_zero_c = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_addr_d = idx;
        state_d   = ST_CAPT;
      end
      ST_CAPT: begin
`ifdef REGDUMP_SKIP_ZERO_EN
        if (rd_data == '0) begin
          if (idx_last_c) begin
            state_d = ST_DONE;
          end else begin
            idx_inc_c = 1'b1;
            state_d   = ST_ISSUE;
          end
        end else begin
          out_data_d  = rd_data;
          out_index_d = idx;
          state_d     = ST_SEND;
        end
`else
        out_data_d  = rd_data;
        out_index_d = idx;
        state_d     = ST_SEND;
`endif
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_last_c) begin
            state_d = ST_DONE;
          end else begin
            idx_inc_c = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_SEND);
  end

  // FSM state and output registers; clr aborts any dump in progress.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule
